// File: rtl/vpu_nonz_pack_if.sv
// Handshake bundle for vpu_nonz_pack: vector input (valid/ready) and sparse beat output (valid/ready).
// Ports: in_valid/in_ready/in_data/in_nonz toward the VPU, out_* beat stream toward the writeback path.
// slave = the packer itself; master = the VPU/writeback environment driving and consuming it.
interface vpu_nonz_pack_if #(
    parameter int P = 64,
    parameter int W = 8,
    parameter int K = 8
);
    localparam int IW = $clog2(P);
    localparam int CW = $clog2(K + 1);
    localparam int NW = $clog2(P + 1);

    logic              in_valid;
    logic              in_ready;
    logic [P*W-1:0]    in_data;
    logic [P-1:0]      in_nonz;
    logic              out_valid;
    logic              out_ready;
    logic [K*W-1:0]    out_data;
    logic [K*IW-1:0]   out_idx;
    logic [CW-1:0]     out_cnt;
    logic              out_last;
    logic [NW-1:0]     out_nnz;

    modport slave (
        input  in_valid, in_data, in_nonz, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_cnt, out_last, out_nnz
    );

    modport master (
        output in_valid, in_data, in_nonz, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_cnt, out_last, out_nnz
    );
endinterface

// File: rtl/vpu_nonz_pack.sv
// Sparse packer: emits nonzero lanes of a P-lane vector as K-slot beats of (data, lane index).
// Latency: first beat valid the cycle after accept; one beat per cycle under continuous out_ready.
// Backpressure: beats held stable while out_ready=0; in_ready only in IDLE or on a last-beat transfer.
// Ports: clk, rst (async active-low), io (slave modport: in_* vector side, out_* beat side).
module vpu_nonz_pack #(
    parameter int P = 64,
    parameter int W = 8,
    parameter int K = 8
) (
    input  logic             clk,
    input  logic             rst,
    vpu_nonz_pack_if.slave   io
);
    localparam int IW = $clog2(P);
    localparam int CW = $clog2(K + 1);
    localparam int NW = $clog2(P + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [P-1:0]     mask_q, mask_d;
    logic [P*W-1:0]   data_q, data_d;
    logic [NW-1:0]    nnz_q, nnz_d;

    // Current beat selection from the remaining mask.
    logic [K*W-1:0]   sel_data;
    logic [K*IW-1:0]  sel_idx;
    logic [P-1:0]     sel_mask;
    logic [CW-1:0]    sel_cnt;
    logic             sel_last;

    // Incoming vector preprocessing.
    logic [P-1:0]     mask_in;
    logic [NW-1:0]    nnz_in;

    logic             accept;
    logic             xfer;
    logic             emit;

    // Walk lanes in ascending order, filling slots until K are taken. Unused
    // slots stay zero, which also gives the zero-fill of slots >= out_cnt.
    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        sel_mask = '0;
        sel_cnt  = '0;
        for (int i = 0; i < P; i++) begin
            if (mask_q[i] && (sel_cnt < CW'(K))) begin
                sel_data[sel_cnt*W +: W]   = data_q[i*W +: W];
                sel_idx[sel_cnt*IW +: IW]  = IW'(i);
                sel_mask[i]                = 1'b1;
                sel_cnt                    = sel_cnt + 1'b1;
            end
        end
        sel_last = ((mask_q & ~sel_mask) == '0);
    end

    // VPU flags arrive MSB-first (bit P-1 is lane 0); store lane-ordered.
    always_comb begin
        mask_in = '0;
        nnz_in  = '0;
        for (int i = 0; i < P; i++) begin
            mask_in[i] = io.in_nonz[P-1-i];
            nnz_in     = nnz_in + NW'(io.in_nonz[i]);
        end
    end

    assign emit   = (state_q == S_EMIT);
    assign xfer   = emit && io.out_ready;
    // rst gates ready so nothing is offered as accepted while held in reset.
    assign io.in_ready = rst && ((state_q == S_IDLE) || (xfer && sel_last));
    assign accept = io.in_valid && io.in_ready;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        nnz_d   = nnz_q;
        if (accept) begin
            // Also covers the last-beat/new-vector overlap: stay in EMIT.
            state_d = S_EMIT;
            mask_d  = mask_in;
            data_d  = io.in_data;
            nnz_d   = nnz_in;
        end else if (xfer) begin
            mask_d = mask_q & ~sel_mask;
            if (sel_last) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            nnz_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            nnz_q   <= nnz_d;
        end
    end

    assign io.out_valid = emit;
    assign io.out_data  = emit ? sel_data : '0;
    assign io.out_idx   = emit ? sel_idx  : '0;
    assign io.out_cnt   = emit ? sel_cnt  : '0;
    assign io.out_last  = emit && sel_last;
    assign io.out_nnz   = emit ? nnz_q    : '0;
endmodule

// File: tb/tb_vpu_nonz_pack.sv
module tb_vpu_nonz_pack;
    localparam int P  = 64;
    localparam int W  = 8;
    localparam int K  = 8;
    localparam int IW = 6;
    localparam int CW = 4;
    localparam int NW = 7;

    typedef struct packed {
        logic [K*W-1:0]  data;
        logic [K*IW-1:0] idx;
        logic [CW-1:0]   cnt;
        logic            last;
        logic [NW-1:0]   nnz;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vpu_nonz_pack_if #(.P(P), .W(W), .K(K)) io ();

    vpu_nonz_pack #(.P(P), .W(W), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int    checks   = 0;
    int    failures = 0;
    int    xfer_cnt = 0;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$];
    int    lanes_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats from an ascending list of flagged lanes.
    task automatic push_expected(input logic [P*W-1:0] d);
        beat_t b;
        int n;
        int c;
        n = lanes_q.size();
        if (n == 0) begin
            b = '0;
            b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int s = 0; s < n; s += K) begin
                b = '0;
                b.nnz = NW'(n);
                c = (n - s < K) ? (n - s) : K;
                for (int j = 0; j < c; j++) begin
                    b.data[j*W +: W]   = d[lanes_q[s+j]*W +: W];
                    b.idx[j*IW +: IW]  = IW'(lanes_q[s+j]);
                end
                b.cnt  = CW'(c);
                b.last = (s + K >= n);
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic logic [P-1:0] nz_from_lanes();
        logic [P-1:0] nz;
        nz = '0;
        foreach (lanes_q[i]) nz[P-1-lanes_q[i]] = 1'b1;
        return nz;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_vec(input logic [P*W-1:0] d, input logic [P-1:0] nz);
        int t;
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.in_nonz  = nz;
        t = 0;
        @(negedge clk);
        while (!io.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!io.in_ready) begin
            chk("accept_timeout", 64'(io.in_ready), 64'd1);
        end else begin
            push_expected(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard.
    bit              stall_v  = 1'b0;
    bit              exp_next = 1'b0;
    logic [K*W-1:0]  h_data;
    logic [K*IW-1:0] h_idx;
    logic [CW-1:0]   h_cnt;
    logic            h_last;
    logic [NW-1:0]   h_nnz;

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            stall_v  = 1'b0;
            exp_next = 1'b0;
        end else begin
            if (exp_next) chk("first_beat_latency", 64'(io.out_valid), 64'd1);
            exp_next = io.in_valid && io.in_ready;
            if (stall_v) begin
                chk("stall_valid", 64'(io.out_valid), 64'd1);
                chk("stall_data", io.out_data, h_data);
                chk("stall_idx", 64'(io.out_idx), 64'(h_idx));
                chk("stall_cnt_last_nnz", 64'({io.out_cnt, io.out_last, io.out_nnz}),
                    64'({h_cnt, h_last, h_nnz}));
            end
            if (!io.out_valid) begin
                chk("idle_zero_outputs",
                    64'(io.out_data | 64'(io.out_idx) | 64'(io.out_cnt) | 64'(io.out_last) | 64'(io.out_nnz)),
                    64'd0);
            end
            if (io.out_valid && io.out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(io.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", io.out_data, e.data);
                    chk("beat_idx", 64'(io.out_idx), 64'(e.idx));
                    chk("beat_cnt", 64'(io.out_cnt), 64'(e.cnt));
                    chk("beat_last", 64'(io.out_last), 64'(e.last));
                    chk("beat_nnz", 64'(io.out_nnz), 64'(e.nnz));
                    if (e.last) chk("ready_on_last", 64'(io.in_ready), 64'd1);
                end
            end
            stall_v = io.out_valid && !io.out_ready;
            h_data = io.out_data;
            h_idx  = io.out_idx;
            h_cnt  = io.out_cnt;
            h_last = io.out_last;
            h_nnz  = io.out_nnz;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            io.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    logic [P*W-1:0] vd;
    logic [P*W-1:0] vd2;
    int base;
    int t;

    initial begin
        io.in_valid  = 1'b0;
        io.in_data   = '0;
        io.in_nonz   = '0;
        io.out_ready = 1'b1;

        // Reset state.
        #12;
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_in_ready", 64'(io.in_ready), 64'd0);
        chk("rst_cnt_last_nnz", 64'({io.out_cnt, io.out_last, io.out_nnz}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_release", 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Dense vector: lane i data = i+1.
        for (int i = 0; i < P; i++) vd[i*W +: W] = W'(i + 1);
        lanes_q.delete();
        for (int i = 0; i < P; i++) lanes_q.push_back(i);
        send_vec(vd, {P{1'b1}});
        io.in_valid = 1'b0;
        drain();

        // All-zero vector.
        lanes_q.delete();
        send_vec(vd, '0);
        io.in_valid = 1'b0;
        drain();

        // Bit-reversal mapping with the literal flag word.
        vd = {P{8'hEE}};
        vd[0*W +: W]  = 8'h11;
        vd[63*W +: W] = 8'hA5;
        lanes_q.delete();
        lanes_q.push_back(0);
        lanes_q.push_back(63);
        send_vec(vd, 64'h8000_0000_0000_0001);
        io.in_valid = 1'b0;
        drain();

        // Partial last beat: 9 lanes.
        for (int i = 0; i < P; i++) vd[i*W +: W] = W'(i) ^ 8'h80;
        lanes_q = '{2, 5, 7, 10, 20, 31, 40, 50, 60};
        send_vec(vd, nz_from_lanes());
        io.in_valid = 1'b0;
        drain();

        // Random backpressure, two vectors back to back.
        rand_rdy = 1'b1;
        for (int i = 0; i < P; i++) vd[i*W +: W] = W'(i * 3 + 7);
        lanes_q.delete();
        for (int i = 0; i < P; i += 5) lanes_q.push_back(i);
        send_vec(vd, nz_from_lanes());
        vd2 = {P{8'h5A}};
        vd2[9*W +: W] = 8'h00;
        lanes_q = '{4, 9, 33};
        send_vec(vd2, nz_from_lanes());
        io.in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 3 of 8 dense beats.
        for (int i = 0; i < P; i++) vd[i*W +: W] = W'(i + 1);
        lanes_q.delete();
        for (int i = 0; i < P; i++) lanes_q.push_back(i);
        base = xfer_cnt;
        send_vec(vd, {P{1'b1}});
        io.in_valid = 1'b0;
        t = 0;
        while (xfer_cnt < base + 3 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk("three_beats_seen", 64'(xfer_cnt - base), 64'd3);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(io.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(io.in_ready), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_midrst", 64'(io.in_ready), 64'd1);
        chk("no_beat_after_midrst", 64'(io.out_valid), 64'd0);
        @(posedge clk);
        #1;
        base = xfer_cnt;
        lanes_q.delete();
        send_vec(vd, '0);
        io.in_valid = 1'b0;
        drain();
        chk("zero_vec_one_beat", 64'(xfer_cnt - base), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
